rans_decoder: RTL and testbench

Streaming rANS decoder, the receive-side counterpart of the rANS encoder. It decodes a word stream produced with the same frequency and cumulative tables. Per symbol it performs a single-cycle parallel slot lookup, a state update, at most one renormalisation word fetch, and a valid/ready symbol emit. It sits between the compressed-word input FIFO and the symbol sink. Tables are loaded through a config port before `start`.

---
 rtl/rans_decoder.sv | 187 ++++++++++++++++++
 tb/tb_rans_decoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_decoder.sv
// rtl/rans_decoder.sv - streaming rANS decoder with single-cycle slot lookup
//
// Decodes a word stream produced by the matching rANS encoder. The
// frequency/cumulative tables are written through the config port while
// idle. A start pulse then decodes num_syms symbols. The first two input
// words form the initial state, most significant word first. Each symbol
// takes one DECODE cycle, zero or more RENORM word fetches, and one EMIT
// handshake.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   config_en/_symbol/_freq/_cumul  table write (ignored while busy)
//   start, num_syms             begin a decode of num_syms symbols
//   in_valid, in_ready, in_data compressed word input stream
//   sym_valid, sym_ready, sym   decoded symbol output stream
//   busy                        FSM not idle
//   done                        one-cycle pulse at the end of a decode
//   err                         sticky error flag, cleared on start
//
// Optional feature macro: RANS_DEC_FINAL_CHECK_EN. When it is defined, the
// final state is compared against L (the encoder's initial state). A
// difference raises err in the same cycle as done.
module rans_decoder #(
  parameter int SYMBOL_WIDTH = 4,
  parameter int NUM_SYMBOLS  = 16,
  parameter int LOG_M        = 10,
  parameter int STATE_WIDTH  = 32,
  parameter int IO_WIDTH     = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    config_en,
  input  logic [SYMBOL_WIDTH-1:0] config_symbol,
  input  logic [LOG_M:0]          config_freq,
  input  logic [LOG_M-1:0]        config_cumul,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_syms,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IO_WIDTH-1:0]     in_data,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [SYMBOL_WIDTH-1:0] sym,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [STATE_WIDTH-1:0] L_BOUND = STATE_WIDTH'(1) << IO_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, DECODE, RENORM, EMIT, FINISH
  } fsm_t;

  fsm_t fsm, fsm_nxt;

  logic [LOG_M:0]          freq_tab  [NUM_SYMBOLS];
  logic [LOG_M-1:0]        cumul_tab [NUM_SYMBOLS];
  logic [STATE_WIDTH-1:0]  state;
  logic [CNT_WIDTH-1:0]    count;
  logic                    err_q;

  logic [LOG_M-1:0]        slot;
  logic                    hit;
  logic [SYMBOL_WIDTH-1:0] hit_idx;
  logic [LOG_M:0]          hit_freq;
  logic [LOG_M-1:0]        hit_cumul;
  logic [STATE_WIDTH-1:0]  dec_state;
  logic [STATE_WIDTH-1:0]  renorm_state;
  logic                    final_miss;

  assign slot = state[LOG_M-1:0];

  // Parallel range compare against every table entry. Scanning from the top
  // index down lets the lowest matching index overwrite the result, so the
  // lowest index wins if entries overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
      if (freq_tab[i] != '0 &&
          (LOG_M+2)'(slot) >= (LOG_M+2)'(cumul_tab[i]) &&
          (LOG_M+2)'(slot) <  (LOG_M+2)'(cumul_tab[i]) + (LOG_M+2)'(freq_tab[i])) begin
        hit     = 1'b1;
        hit_idx = SYMBOL_WIDTH'(i);
      end
    end
  end

  assign hit_freq     = freq_tab[hit_idx];
  assign hit_cumul    = cumul_tab[hit_idx];
  assign dec_state    = STATE_WIDTH'(hit_freq) * (state >> LOG_M)
                      + STATE_WIDTH'(slot) - STATE_WIDTH'(hit_cumul);
  assign renorm_state = {state[STATE_WIDTH-IO_WIDTH-1:0], in_data};

`ifdef RANS_DEC_FINAL_CHECK_EN
  assign final_miss = (fsm == FINISH) && (state != L_BOUND);
`else
  assign final_miss = 1'b0;
`endif

  // err is visible in the FINISH cycle itself, and is also latched so that
  // it stays set afterwards.
  assign err = err_q | final_miss;

  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    done      = 1'b0;
    busy      = (fsm != IDLE);
    case (fsm)
      IDLE: begin
        if (start) fsm_nxt = (num_syms == '0) ? FINISH : LOAD_HI;
      end
      LOAD_HI: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = LOAD_LO;
      end
      LOAD_LO: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = DECODE;
      end
      DECODE: begin
        fsm_nxt = (hit && dec_state < L_BOUND) ? RENORM : EMIT;
      end
      RENORM: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = (renorm_state < L_BOUND) ? RENORM : EMIT;
      end
      EMIT: begin
        sym_valid = 1'b1;
        if (sym_ready) fsm_nxt = (count == CNT_WIDTH'(1)) ? FINISH : DECODE;
      end
      FINISH: begin
        done    = 1'b1;
        fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      state <= '0;
      count <= '0;
      sym   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_SYMBOLS; i++) begin
        freq_tab[i]  <= '0;
        cumul_tab[i] <= '0;
      end
    end else begin
      fsm <= fsm_nxt;
      if (config_en && fsm == IDLE) begin
        freq_tab[config_symbol]  <= config_freq;
        cumul_tab[config_symbol] <= config_cumul;
      end
      case (fsm)
        IDLE: begin
          if (start) begin
            count <= num_syms;
            err_q <= 1'b0;
          end
        end
        LOAD_HI: if (in_valid) state[STATE_WIDTH-1 -: IO_WIDTH] <= in_data;
        LOAD_LO: if (in_valid) state[IO_WIDTH-1:0] <= in_data;
        DECODE: begin
          if (hit) begin
            state <= dec_state;
            sym   <= hit_idx;
          end else begin
            err_q <= 1'b1;
            sym   <= '0;
          end
        end
        RENORM: if (in_valid) state <= renorm_state;
        EMIT:   if (sym_ready) count <= count - CNT_WIDTH'(1);
        FINISH: if (final_miss) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_decoder.sv
// tb/tb_rans_decoder.sv - self-checking bench for rans_decoder
module tb_rans_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        config_en;
  logic [3:0]  config_symbol;
  logic [10:0] config_freq;
  logic [9:0]  config_cumul;
  logic        start;
  logic [15:0] num_syms;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  rans_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .config_en(config_en), .config_symbol(config_symbol),
    .config_freq(config_freq), .config_cumul(config_cumul),
    .start(start), .num_syms(num_syms),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  int t_freq [16];
  int t_cumul[16];
  logic [15:0] words[$];

  // reference model results
  int          m_syms[$];
  logic [31:0] m_state;
  int          m_cons;
  bit          m_miss;

  // DUT observation results
  int          d_syms[$];
  logic [31:0] d_state;
  int          d_cons;
  bit          d_done;
  bit          d_err;
  bit          d_unstable;

  typedef struct {
    int          tab_id;
    int          num;
    logic [15:0] w[4];
    int          exp_sym;     // -1: no symbol expected
    logic [31:0] exp_state;
    int          exp_cons;
    bit          exp_miss;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic bit final_err(input logic [31:0] st);
`ifdef RANS_DEC_FINAL_CHECK_EN
    return st != 32'h0001_0000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_tables(input int id);
    for (int i = 0; i < 16; i++) begin
      t_freq[i]  = 0;
      t_cumul[i] = 0;
    end
    if (id == 1) begin
      t_freq[0] = 1000; t_cumul[0] = 0;
      t_freq[1] = 24;   t_cumul[1] = 1000;
    end else begin
      for (int i = 0; i < 16; i++) begin
        t_freq[i]  = 64;
        t_cumul[i] = 64 * i;
      end
      if (id == 2) t_freq[13] = 0;
    end
  endtask

  task automatic load_tables();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      config_en     = 1'b1;
      config_symbol = 4'(i);
      config_freq   = 11'(t_freq[i]);
      config_cumul  = 10'(t_cumul[i]);
    end
    @(negedge clk);
    config_en = 1'b0;
  endtask

  // Straight arithmetic decode of the word list using the table arrays.
  task automatic ref_model(input int num);
    longint st;
    longint slot;
    int     p;
    int     s;
    m_syms.delete();
    m_miss = 1'b0;
    m_cons = 0;
    if (num == 0) return;
    st = (longint'(words[0]) * 65536) + longint'(words[1]);
    p  = 2;
    for (int k = 0; k < num; k++) begin
      slot = st % 1024;
      s = -1;
      for (int i = 0; i < 16; i++)
        if (s < 0 && t_freq[i] != 0 && slot >= t_cumul[i] && slot < t_cumul[i] + t_freq[i])
          s = i;
      if (s < 0) begin
        m_miss = 1'b1;
        m_syms.push_back(0);
      end else begin
        st = (longint'(t_freq[s]) * (st / 1024) + slot - t_cumul[s]) % 64'h1_0000_0000;
        m_syms.push_back(s);
        while (st < 65536) begin
          st = ((st * 65536) + longint'(words[p])) % 64'h1_0000_0000;
          p++;
        end
      end
    end
    m_state = 32'(st);
    m_cons  = p;
  endtask

  // mode 0: no stalls; 1: random stalls; 2: fixed stalls (3 cycles of
  // in_valid=0 once the initial state is loaded, 5 cycles of sym_ready=0).
  task automatic run_dut(input int num, input int mode);
    logic [15:0] q[$];
    int   iv_hold;
    int   sr_hold;
    logic [3:0] held;
    bit   iv, sr;
    q = words;
    d_syms.delete();
    d_cons = 0; d_done = 0; d_err = 0; d_unstable = 0; d_state = '0;
    iv_hold = 3; sr_hold = 5; held = '0;
    @(negedge clk);
    num_syms = 16'(num);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        d_done  = 1'b1;
        d_err   = err;
        d_state = dut.state;
        break;
      end
      iv = 1'b1;
      sr = 1'b1;
      if (mode == 1) begin
        iv = ($urandom_range(0, 3) != 0);
        sr = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (d_cons >= 2 && in_ready && iv_hold > 0) begin
          iv = 1'b0;
          iv_hold--;
        end
        if (sym_valid && sr_hold > 0) begin
          if (sr_hold == 5) held = sym;
          else if (sym !== held) d_unstable = 1'b1;
          sr = 1'b0;
          sr_hold--;
        end
      end
      if (q.size() == 0) iv = 1'b0;
      in_valid  = iv;
      in_data   = (q.size() != 0) ? q[0] : 16'h0;
      sym_ready = sr;
      if (in_valid && in_ready) begin
        void'(q.pop_front());
        d_cons++;
      end
      if (sym_valid && sym_ready) d_syms.push_back(int'(sym));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    sym_ready = 1'b0;
  endtask

  task automatic compare_run(input string name, input int exp_q[$], input logic [31:0] exp_state,
                             input int exp_cons, input bit exp_err);
    check({name, ".done"}, 64'(d_done), 64'd1);
    check({name, ".nsyms"}, 64'(d_syms.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < d_syms.size(); i++)
      check($sformatf("%s.sym%0d", name, i), 64'(d_syms[i]), 64'(exp_q[i]));
    check({name, ".state"}, 64'(d_state), 64'(exp_state));
    check({name, ".consumed"}, 64'(d_cons), 64'(exp_cons));
    check({name, ".err"}, 64'(d_err), 64'(exp_err));
  endtask

  vec_t vecs[5];

  initial begin
    int eq[$];
    int cuts[$];

    vecs[0] = '{0, 1, '{16'h0001, 16'h2345, 16'hABCD, 16'h5555}, 13, 32'h1205ABCD, 3, 1'b0};
    vecs[1] = '{0, 0, '{16'h0001, 16'h2345, 16'hABCD, 16'h5555}, -1, 32'h1205ABCD, 0, 1'b0};
    vecs[2] = '{1, 1, '{16'h0001, 16'h03F0, 16'h0000, 16'h7777}, 1, 32'h06080000, 3, 1'b0};
    vecs[3] = '{1, 1, '{16'h0001, 16'h0000, 16'h1111, 16'h7777}, 0, 32'hFA001111, 3, 1'b0};
    vecs[4] = '{2, 1, '{16'h0001, 16'h2345, 16'hABCD, 16'h5555}, 0, 32'h00012345, 2, 1'b1};

    rst_n = 1'b0; config_en = 1'b0; config_symbol = '0; config_freq = '0; config_cumul = '0;
    start = 1'b0; num_syms = '0; in_valid = 1'b0; in_data = '0; sym_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    check("reset.sym_valid", 64'(sym_valid), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err", 64'(err), 64'd0);
    check("reset.sym", 64'(sym), 64'd0);
    rst_n = 1'b1;

    // directed vectors
    for (int v = 0; v < 5; v++) begin
      set_tables(vecs[v].tab_id);
      load_tables();
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back(vecs[v].w[i]);
      run_dut(vecs[v].num, 0);
      eq.delete();
      if (vecs[v].exp_sym >= 0) eq.push_back(vecs[v].exp_sym);
      compare_run($sformatf("vec%0d", v), eq, vecs[v].exp_state, vecs[v].exp_cons,
                  vecs[v].exp_miss | final_err(vecs[v].exp_state));
    end

    // backpressure: fixed stalls on case-1 stimulus, same result as unstalled
    set_tables(0);
    load_tables();
    words = '{16'h0001, 16'h2345, 16'hABCD, 16'h5555};
    run_dut(1, 2);
    check("stall.sym_stable", 64'(d_unstable), 64'd0);
    eq = '{13};
    compare_run("stall", eq, 32'h1205ABCD, 3, final_err(32'h1205ABCD));

    // reset in the middle of RENORM
    words = '{16'h0001, 16'h2345};
    @(negedge clk);
    num_syms = 16'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    @(negedge clk);
    in_data  = 16'h2345;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid.in_ready", 64'(in_ready), 64'd1);
    check("mid.busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.sym_valid", 64'(sym_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rst.freq%0d", i), 64'(dut.freq_tab[i]), 64'd0);
      check($sformatf("rst.cumul%0d", i), 64'(dut.cumul_tab[i]), 64'd0);
    end
    load_tables();
    words = '{16'h0001, 16'h2345, 16'hABCD, 16'h5555};
    run_dut(1, 0);
    eq = '{13};
    compare_run("after_rst", eq, 32'h1205ABCD, 3, final_err(32'h1205ABCD));

    // randomized tables, streams and backpressure against the model
    for (int it = 0; it < 25; it++) begin
      int num;
      cuts.delete();
      cuts.push_back(0);
      cuts.push_back(1024);
      for (int i = 0; i < 15; i++) cuts.push_back(int'($urandom_range(0, 1024)));
      cuts.sort();
      for (int i = 0; i < 16; i++) begin
        t_freq[i]  = cuts[i+1] - cuts[i];
        t_cumul[i] = (t_freq[i] == 0) ? 0 : cuts[i];
      end
      if ($urandom_range(0, 3) == 0) t_freq[$urandom_range(0, 15)] = 0;
      load_tables();
      num = int'($urandom_range(1, 12));
      words.delete();
      for (int i = 0; i < 2 * num + 4; i++) words.push_back(16'($urandom_range(1, 65535)));
      ref_model(num);
      run_dut(num, (it % 4 == 0) ? 0 : 1);
      compare_run($sformatf("rand%0d", it), m_syms, m_state, m_cons, m_miss | final_err(m_state));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
